// File: rtl/vecwrite.sv
// Result write-back serialiser: captures a packed result vector on ST and writes it
// word by word into a synchronous memory port. Optional checksum word: VECWRITE_CHECKSUM_EN.
module vecwrite #(
    parameter int words         = 10,
    parameter int data_width    = 32,
    parameter int address_width = 4,
    parameter int base_addr     = 0
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [words*data_width-1:0]   IN,
    input  logic                          ST,
    input  logic                          WAIT,
    output logic [address_width-1:0]      ADDR,
    output logic [data_width-1:0]         WDATA,
    output logic                          WR,
    output logic                          BUSY,
    output logic                          RD,
    output logic                          OVF
);

    localparam int CNT_W = (words < 2) ? 1 : $clog2(words + 1);
    localparam logic [address_width-1:0] BASE = address_width'(base_addr);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } state_t;

    state_t                 state;
    logic [data_width-1:0]  cap [words];
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       nxt_cnt;
    logic [data_width-1:0]  nxt_data;

`ifdef VECWRITE_CHECKSUM_EN
    // The checksum occupies slot index 'words', one past the last data word.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(words);
    logic [data_width-1:0] csum;

    always_comb begin
        csum = '0;
        for (int unsigned i = 0; i < words; i++) begin
            csum = csum ^ cap[i];
        end
    end
`else
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(words - 1);
`endif

    always_comb begin
        nxt_cnt  = cnt + CNT_W'(1);
        nxt_data = '0;
        if (nxt_cnt < CNT_W'(words)) begin
            nxt_data = cap[nxt_cnt];
        end
`ifdef VECWRITE_CHECKSUM_EN
        else begin
            nxt_data = csum;
        end
`endif
    end

    // Word 0 is presented from the capture edge, so LOAD already carries a live
    // write; a stall there is absorbed by WRITE holding counter 0.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            cnt   <= '0;
            ADDR  <= BASE;
            WDATA <= '0;
            WR    <= 1'b0;
            BUSY  <= 1'b0;
            RD    <= 1'b0;
            OVF   <= 1'b0;
            for (int unsigned i = 0; i < words; i++) begin
                cap[i] <= '0;
            end
        end else begin
            RD <= 1'b0;
            if (ST && state != IDLE) begin
                OVF <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (ST) begin
                        for (int unsigned i = 0; i < words; i++) begin
                            cap[i] <= IN[i*data_width +: data_width];
                        end
                        cnt   <= '0;
                        ADDR  <= BASE;
                        WDATA <= IN[data_width-1:0];
                        WR    <= 1'b1;
                        BUSY  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD, WRITE: begin
                    if (!WAIT) begin
                        if (cnt == LAST_IDX) begin
                            WR    <= 1'b0;
                            BUSY  <= 1'b0;
                            RD    <= 1'b1;
                            state <= DONE;
                        end else begin
                            cnt   <= nxt_cnt;
                            ADDR  <= BASE + address_width'(nxt_cnt);
                            WDATA <= nxt_data;
                            state <= WRITE;
                        end
                    end else begin
                        state <= WRITE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vecwrite.sv
// Scoreboard bench for vecwrite: expected memory writes queued at ST, checked on acceptance.
module tb_vecwrite;

`ifdef VECWRITE_CHECKSUM_EN
    localparam int NW = 11;
`else
    localparam int NW = 10;
`endif

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic         CLK = 1'b0;
    logic         RST;
    logic [319:0] IN;
    logic         ST, ST1, WAIT;
    logic [3:0]   addr0, addr1;
    logic [31:0]  wdata0, wdata1;
    logic         wr0, wr1, busy0, busy1, rd0, rd1, ovf0, ovf1;

    int checks   = 0;
    int failures = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 CLK = ~CLK;

    vecwrite #(.words(10), .data_width(32), .address_width(4), .base_addr(0)) u0 (
        .CLK(CLK), .RST(RST), .IN(IN), .ST(ST), .WAIT(WAIT),
        .ADDR(addr0), .WDATA(wdata0), .WR(wr0), .BUSY(busy0), .RD(rd0), .OVF(ovf0)
    );

    vecwrite #(.words(10), .data_width(32), .address_width(4), .base_addr(12)) u1 (
        .CLK(CLK), .RST(RST), .IN(IN), .ST(ST1), .WAIT(WAIT),
        .ADDR(addr1), .WDATA(wdata1), .WR(wr1), .BUSY(busy1), .RD(rd1), .OVF(ovf1)
    );

    // Write acceptance monitors: a write lands on the next rising edge if WR=1, WAIT=0.
    always @(negedge CLK) begin
        if (RST && wr0 && !WAIT) begin
            checks++;
            assert (q0.size() > 0) else begin
                failures++;
                $error("FAIL u0_unexpected_write: observed addr=%0h data=%0h expected no write", addr0, wdata0);
            end
            if (q0.size() > 0) begin
                exp_t e;
                e = q0.pop_front();
                checks++;
                assert (addr0 === e.addr) else begin
                    failures++;
                    $error("FAIL u0_addr: observed=%0h expected=%0h", addr0, e.addr);
                end
                checks++;
                assert (wdata0 === e.data) else begin
                    failures++;
                    $error("FAIL u0_data: observed=%0h expected=%0h", wdata0, e.data);
                end
            end
        end
        if (RST && wr1 && !WAIT) begin
            checks++;
            assert (q1.size() > 0) else begin
                failures++;
                $error("FAIL u1_unexpected_write: observed addr=%0h data=%0h expected no write", addr1, wdata1);
            end
            if (q1.size() > 0) begin
                exp_t e;
                e = q1.pop_front();
                checks++;
                assert (addr1 === e.addr) else begin
                    failures++;
                    $error("FAIL u1_addr: observed=%0h expected=%0h", addr1, e.addr);
                end
                checks++;
                assert (wdata1 === e.data) else begin
                    failures++;
                    $error("FAIL u1_data: observed=%0h expected=%0h", wdata1, e.data);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [319:0] mkvec(input logic [31:0] b);
        logic [319:0] r;
        for (int k = 0; k < 10; k++) r[k*32 +: 32] = b + 32'(k);
        return r;
    endfunction

    task automatic push_exp(input bit which, input logic [319:0] v, input int unsigned base);
        exp_t e;
        logic [31:0] acc;
        acc = '0;
        for (int k = 0; k < 10; k++) begin
            e.addr = 4'((base + 32'(k)) % 16);
            e.data = v[k*32 +: 32];
            acc    = acc ^ e.data;
            if (which) q1.push_back(e); else q0.push_back(e);
        end
`ifdef VECWRITE_CHECKSUM_EN
        e.addr = 4'((base + 10) % 16);
        e.data = acc;
        if (which) q1.push_back(e); else q0.push_back(e);
`endif
    endtask

    task automatic start0(input logic [319:0] v);
        push_exp(1'b0, v, 0);
        IN = v;
        ST = 1'b1;
        step();
        ST = 1'b0;
    endtask

    // n counts cycles after the capture edge; WR is high for n=1..NW+stall.
    task automatic run_body(input int stall_at, input int stall_len, input bit hostile);
        int total;
        total = NW + stall_len;
        for (int n = 1; n <= total; n++) begin
            WAIT = (n >= stall_at && n < stall_at + stall_len);
            if (hostile && n == 1) IN = '1;
            ST = (hostile && n == 3);
            if (hostile && n == 3) chk("ovf_before", 32'(ovf0), 32'd0);
            if (hostile && n == 4) chk("ovf_after", 32'(ovf0), 32'd1);
            chk("wr_active", 32'(wr0), 32'd1);
            chk("busy_active", 32'(busy0), 32'd1);
            chk("rd_quiet", 32'(rd0), 32'd0);
            if (n >= stall_at && n <= stall_at + stall_len)
                chk("addr_hold", 32'(addr0), 32'(stall_at - 1));
            step();
        end
        WAIT = 1'b0;
        ST   = 1'b0;
        chk("rd_pulse", 32'(rd0), 32'd1);
        chk("wr_done", 32'(wr0), 32'd0);
        chk("busy_done", 32'(busy0), 32'd0);
        step();
        chk("rd_single", 32'(rd0), 32'd0);
        step();
    endtask

    initial begin
        RST = 1'b0; IN = '0; ST = 1'b0; ST1 = 1'b0; WAIT = 1'b0;
        #12;
        chk("rst_addr", 32'(addr0), 32'd0);
        chk("rst_addr_b12", 32'(addr1), 32'd12);
        chk("rst_wdata", wdata0, 32'd0);
        chk("rst_wr", 32'(wr0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_rd", 32'(rd0), 32'd0);
        chk("rst_ovf", 32'(ovf0), 32'd0);
        step();
        RST = 1'b1;
        step();

        // Plain run, words 1..10 at base 0
        start0(mkvec(32'd1));
        run_body(3, 0, 1'b0);
        chk("ovf_clean", 32'(ovf0), 32'd0);

        // Stall on word 2 for three cycles
        start0(mkvec(32'h11));
        run_body(3, 3, 1'b0);

        // Base 12: address wrap
        push_exp(1'b1, mkvec(32'hA0), 12);
        IN = mkvec(32'hA0);
        ST1 = 1'b1;
        step();
        ST1 = 1'b0;
        for (int n = 1; n <= NW; n++) begin
            chk("u1_wr", 32'(wr1), 32'd1);
            if (n == 5) chk("u1_wrap_addr", 32'(addr1), 32'd0);
            step();
        end
        chk("u1_rd", 32'(rd1), 32'd1);
        step();
        chk("u1_rd_single", 32'(rd1), 32'd0);

        // IN corrupted after capture, ST re-pulsed while busy
        start0(mkvec(32'd1));
        run_body(3, 0, 1'b1);
        chk("ovf_sticky", 32'(ovf0), 32'd1);

        // Reset while word 5 is presented
        start0(mkvec(32'h100));
        for (int n = 1; n <= 5; n++) step();
        chk("pre_rst_addr", 32'(addr0), 32'd5);
        RST = 1'b0;
        #1;
        chk("midrst_wr", 32'(wr0), 32'd0);
        chk("midrst_busy", 32'(busy0), 32'd0);
        chk("midrst_rd", 32'(rd0), 32'd0);
        chk("midrst_addr", 32'(addr0), 32'd0);
        chk("midrst_ovf", 32'(ovf0), 32'd0);
        chk("abandoned_words", 32'(q0.size()), 32'(NW - 5));
        q0.delete();
        step();
        RST = 1'b1;
        for (int n = 0; n < 3; n++) begin
            chk("post_rst_rd", 32'(rd0), 32'd0);
            chk("post_rst_wr", 32'(wr0), 32'd0);
            step();
        end
        start0(mkvec(32'h200));
        run_body(3, 0, 1'b0);

        step();
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vecwrite.md
Name: vecwrite

Overview:
- Write-back end of the matrix-vector datapath. The multiplier array reads operands from synchronous memories; this block takes the opposite direction.
- It captures the packed result vector on the done strobe and serialises it, one word per accepted cycle, into a synchronous write-port memory.
- Sits between the multiplier top (OUT/RD) and the result memory; its RD output tells the sequencer that the result is committed.

Parameters:
words, 10, number of result words in the packed input vector
data_width, 32, bits per word
address_width, 4, memory address width
base_addr, 0, memory address of word 0

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  reset, asynchronous, active-low (RST=0 resets)
IN  input  words*data_width  packed result vector; word i = IN[(i+1)*data_width-1 : i*data_width]
ST  input  1  capture strobe (driven from multiplier RD), sampled in IDLE only
WAIT  input  1  memory stall; while 1, the current write is held and not accepted
ADDR  output  address_width  write address
WDATA  output  data_width  write data
WR  output  1  write enable; a write is accepted on a rising edge with WR=1 and WAIT=0
BUSY  output  1  high in LOAD/WRITE
RD  output  1  one-cycle pulse, all words committed
OVF  output  1  sticky; ST seen while busy

Behaviour:
- Reset (RST=0, async): state=IDLE, ADDR=base_addr, WDATA=0, WR=0, BUSY=0, RD=0, OVF=0, word counter=0, capture register cleared.
- FSM: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - ST=1 at an edge -> capture IN into an internal words*data_width register; counter=0; go to LOAD.
  - ST=0 -> stay in IDLE.
- LOAD (1 cycle):
  - Drive ADDR=base_addr, WDATA=word 0, WR=1, BUSY=1.
  - Go to WRITE.
- WRITE:
  - WR=1, ADDR=(base_addr+counter) mod 2^address_width, WDATA=word[counter].
  - Edge with WAIT=0 and counter<words-1: counter++; ADDR/WDATA update on that edge.
  - Edge with WAIT=0 and counter=words-1: go to DONE; WR=0 and BUSY=0 from the next cycle.
  - WAIT=1: ADDR, WDATA and WR all held; counter unchanged.
- DONE:
  - RD=1 for exactly one cycle; go to IDLE.
  - ST sampled in DONE is ignored.
  - A new capture is possible at the first IDLE edge after DONE.
- Latency, WAIT=0: ST edge at cycle 0 -> word k written at cycle k+1 -> RD high during cycle words+1. Total words+2 cycles from ST to IDLE.
- ST while in LOAD/WRITE/DONE: ignored; the capture register is not touched; OVF<=1.
  - OVF is cleared only by reset.
- Capture isolation: IN may change freely after the capture edge; written data always equals the captured value.
- Address wrap: base_addr+counter wraps modulo 2^address_width with no error flag.
- words=1: LOAD then a single WRITE acceptance, then DONE.
- Reset mid-operation: immediate return to the reset values above. No partial RD pulse; remaining words are abandoned.
- WR never asserts outside LOAD/WRITE. RD and WR are never high in the same cycle.

Optional Feature:
- Macro VECWRITE_CHECKSUM_EN.
- Defined:
  - After word words-1 is accepted, one extra write is issued: ADDR=(base_addr+words) mod 2^address_width, WDATA = XOR of all captured words.
  - The checksum write obeys the same WAIT rules.
  - RD follows its acceptance, so latency is words+3 cycles with WAIT=0.
- Undefined: no extra write; no checksum logic synthesised.

Test Plan:
- Reset then ST pulse, IN words = 1..10, base_addr=0, WAIT=0 -> writes (0,1)..(9,10) on consecutive cycles 1..10; RD=1 only in cycle 11; BUSY low again at cycle 11.
- Same, with WAIT=1 during cycles 3-5 -> word 2 is held at ADDR=2 for 4 cycles with no duplicate acceptance; RD delayed by 3 cycles.
- base_addr=12, words=10 -> addresses 12,13,14,15,0,1..5 (wrap-around).
- IN changed to all 0xFFFFFFFF one cycle after ST -> memory contents still 1..10. ST re-pulsed at cycle 4 -> OVF=1, sequence unaffected.
- RST=0 asserted during word 5 -> WR/BUSY drop immediately, no RD. A fresh ST after release writes all 10 words from word 0.
- With VECWRITE_CHECKSUM_EN, IN=1..10 -> 11th write at ADDR=10 with data 0x0000000B (XOR of 1..10); RD in cycle 12.
